// File: rtl/pmem_pkg.sv
// Shared types for the data-memory port arbiter and its grant logic.
// Holds the FSM states, the requester encoding and the bus widths.
package pmem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic             wen;
    logic [MASKW-1:0] wmask;
    logic [XLEN-1:0]  wdata;
  } req_t;

endpackage

// File: rtl/pmem_grant.sv
// Two-requester fixed priority (LSU first) with IFU anti-starvation; purely combinational.
// The caller applies starve_nxt only in a cycle where a grant is actually taken.
module pmem_grant
  import pmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          ifu_vld,
  input  logic          lsu_vld,
  input  logic [SW-1:0] starve_cnt,
  output logic [1:0]    gnt,
  output logic [SW-1:0] starve_nxt
);

  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic ifu_starved;

  assign ifu_starved = ifu_vld && (starve_cnt == SMAX);

  always_comb begin
    gnt        = '0;
    starve_nxt = starve_cnt;
    if (lsu_vld && !ifu_starved) begin
      gnt[OWN_LSU] = 1'b1;
      if (!ifu_vld) begin
        starve_nxt = '0;
      end else if (starve_cnt != SMAX) begin
        starve_nxt = starve_cnt + SW'(1);
      end
    end else if (ifu_vld) begin
      gnt[OWN_IFU] = 1'b1;
      starve_nxt   = '0;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one combinational-read memory port between IFU and LSU, one transaction at a time.
// Accept to resp_valid is LATENCY+1 cycles; requests are only accepted in IDLE, responses wait for resp_ready.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_req_valid,
  output logic             ifu_req_ready,
  input  logic [XLEN-1:0]  ifu_addr,
  output logic             ifu_resp_valid,
  input  logic             ifu_resp_ready,
  output logic [XLEN-1:0]  ifu_rdata,
  input  logic             lsu_req_valid,
  output logic             lsu_req_ready,
  input  logic [XLEN-1:0]  lsu_addr,
  input  logic             lsu_wen,
  input  logic [MASKW-1:0] lsu_wmask,
  input  logic [XLEN-1:0]  lsu_wdata,
  output logic             lsu_resp_valid,
  input  logic             lsu_resp_ready,
  output logic [XLEN-1:0]  lsu_rdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [MASKW-1:0] mem_mask,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  req_t            req_q, req_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d, starve_nxt;
  logic [XLEN-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic            ifu_resp_valid_q, ifu_resp_valid_d;
  logic            lsu_resp_valid_q, lsu_resp_valid_d;
  logic            mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [1:0]      gnt;
  logic            idle;

  pmem_grant #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_grant (
    .ifu_vld    (ifu_req_valid),
    .lsu_vld    (lsu_req_valid),
    .starve_cnt (starve_q),
    .gnt        (gnt),
    .starve_nxt (starve_nxt)
  );

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign idle          = rst_n && (state_q == IDLE);
  assign ifu_req_ready = idle && gnt[OWN_IFU];
  assign lsu_req_ready = idle && gnt[OWN_LSU];

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    req_d            = req_q;
    cnt_d            = cnt_q;
    starve_d         = starve_q;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_rdata_d      = lsu_rdata_q;
    ifu_resp_valid_d = ifu_resp_valid_q;
    lsu_resp_valid_d = lsu_resp_valid_q;
    mem_re_d         = 1'b0;
    mem_we_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifu_req_ready || lsu_req_ready) begin
          owner_d  = lsu_req_ready ? OWN_LSU : OWN_IFU;
          if (lsu_req_ready) begin
            req_d.addr  = lsu_addr;
            req_d.wen   = lsu_wen;
            req_d.wmask = lsu_wmask;
            req_d.wdata = lsu_wdata;
          end else begin
            req_d.addr  = ifu_addr;
            req_d.wen   = 1'b0;
            req_d.wmask = '0;
            req_d.wdata = '0;
          end
          starve_d = starve_nxt;
          cnt_d    = CW'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d  = ACCESS;
            mem_re_d = !req_d.wen;
            mem_we_d = req_d.wen;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d  = ACCESS;
          mem_re_d = !req_q.wen;
          mem_we_d = req_q.wen;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == OWN_LSU) begin
          lsu_rdata_d      = req_q.wen ? '0 : mem_rdata;
          lsu_resp_valid_d = 1'b1;
        end else begin
          ifu_rdata_d      = mem_rdata;
          ifu_resp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if ((owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready) begin
          state_d          = IDLE;
          ifu_resp_valid_d = 1'b0;
          lsu_resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      req_q            <= '0;
      cnt_q            <= '0;
      starve_q         <= '0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      mem_re_q         <= 1'b0;
      mem_we_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      req_q            <= req_d;
      cnt_q            <= cnt_d;
      starve_q         <= starve_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_rdata_q      <= lsu_rdata_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      mem_re_q         <= mem_re_d;
      mem_we_q         <= mem_we_d;
    end
  end

  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign mem_re         = mem_re_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = req_q.addr;
  assign mem_mask       = req_q.wmask;
  assign mem_wdata      = req_q.wdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: instance 0 runs LATENCY=1, instance 1 runs LATENCY=3.
// Accepted requests push expected responses; response handshakes pop and compare.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ifu_req_valid [2], ifu_req_ready [2], ifu_resp_valid [2], ifu_resp_ready [2];
  logic        lsu_req_valid [2], lsu_req_ready [2], lsu_wen [2], lsu_resp_valid [2], lsu_resp_ready [2];
  logic        mem_re [2], mem_we [2];
  logic [31:0] ifu_addr [2], ifu_rdata [2], lsu_addr [2], lsu_wdata [2], lsu_rdata [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [7:0]  lsu_wmask [2], mem_mask [2];

  pmem_arbiter #(.LATENCY(1), .STARVE_MAX(4)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid[0]), .ifu_req_ready(ifu_req_ready[0]), .ifu_addr(ifu_addr[0]),
    .ifu_resp_valid(ifu_resp_valid[0]), .ifu_resp_ready(ifu_resp_ready[0]), .ifu_rdata(ifu_rdata[0]),
    .lsu_req_valid(lsu_req_valid[0]), .lsu_req_ready(lsu_req_ready[0]), .lsu_addr(lsu_addr[0]),
    .lsu_wen(lsu_wen[0]), .lsu_wmask(lsu_wmask[0]), .lsu_wdata(lsu_wdata[0]),
    .lsu_resp_valid(lsu_resp_valid[0]), .lsu_resp_ready(lsu_resp_ready[0]), .lsu_rdata(lsu_rdata[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_mask(mem_mask[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  pmem_arbiter #(.LATENCY(3), .STARVE_MAX(4)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid[1]), .ifu_req_ready(ifu_req_ready[1]), .ifu_addr(ifu_addr[1]),
    .ifu_resp_valid(ifu_resp_valid[1]), .ifu_resp_ready(ifu_resp_ready[1]), .ifu_rdata(ifu_rdata[1]),
    .lsu_req_valid(lsu_req_valid[1]), .lsu_req_ready(lsu_req_ready[1]), .lsu_addr(lsu_addr[1]),
    .lsu_wen(lsu_wen[1]), .lsu_wmask(lsu_wmask[1]), .lsu_wdata(lsu_wdata[1]),
    .lsu_resp_valid(lsu_resp_valid[1]), .lsu_resp_ready(lsu_resp_ready[1]), .lsu_rdata(lsu_rdata[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_mask(mem_mask[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Memory behind the port: combinational read, byte-masked write at the clock edge.
  logic [31:0] ram [256];
  assign mem_rdata[0] = ram[mem_addr[0][9:2]];
  assign mem_rdata[1] = ram[mem_addr[1][9:2]];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (mem_we[k])
          for (int b = 0; b < 4; b++)
            if (mem_mask[k][b]) ram[mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
    end
  end

  typedef struct {
    int          k;
    logic        own;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q [$];
  logic        gnt_log [$];
  logic [31:0] model [int];
  int          we_cnt [2];
  int          re_cnt [2];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int i;
    i = int'(a[9:2]);
    return model.exists(i) ? model[i] : pat(i);
  endfunction

  task automatic sb_pop(input int k, input logic own, input logic [31:0] rdata);
    exp_t        e;
    logic [31:0] w;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("sb_inst", 32'(k), 32'(e.k));
    chk("sb_owner", 32'(own), 32'(e.own));
    chk("sb_rdata", rdata, e.rdata);
    if (e.wen) begin
      w = model_rd(e.addr);
      for (int b = 0; b < 4; b++)
        if (e.mask[b]) w[8*b +: 8] = e.wdata[8*b +: 8];
      model[int'(e.addr[9:2])] = w;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) we_cnt[k]++;
      if (mem_re[k]) re_cnt[k]++;
      if (rst_n) begin
        if (ifu_req_valid[k] && ifu_req_ready[k]) begin
          e.k = k; e.own = 1'b0; e.rdata = model_rd(ifu_addr[k]);
          e.wen = 1'b0; e.addr = ifu_addr[k]; e.mask = 8'h00; e.wdata = 32'h0;
          exp_q.push_back(e);
          gnt_log.push_back(1'b0);
        end
        if (lsu_req_valid[k] && lsu_req_ready[k]) begin
          e.k = k; e.own = 1'b1; e.rdata = lsu_wen[k] ? 32'h0 : model_rd(lsu_addr[k]);
          e.wen = lsu_wen[k]; e.addr = lsu_addr[k]; e.mask = lsu_wmask[k]; e.wdata = lsu_wdata[k];
          exp_q.push_back(e);
          gnt_log.push_back(1'b1);
        end
        if (ifu_resp_valid[k] && ifu_resp_ready[k]) sb_pop(k, 1'b0, ifu_rdata[k]);
        if (lsu_resp_valid[k] && lsu_resp_ready[k]) sb_pop(k, 1'b1, lsu_rdata[k]);
      end
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic xact(input int k, input logic lsu, input logic [31:0] addr, input logic wen,
                      input logic [7:0] mask, input logic [31:0] wdata);
    logic ok;
    ok = 1'b0;
    drive_pt();
    if (lsu) begin
      lsu_req_valid[k] = 1'b1; lsu_addr[k] = addr; lsu_wen[k] = wen;
      lsu_wmask[k] = mask; lsu_wdata[k] = wdata; lsu_resp_ready[k] = 1'b1;
    end else begin
      ifu_req_valid[k] = 1'b1; ifu_addr[k] = addr; ifu_resp_ready[k] = 1'b1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = lsu ? lsu_req_ready[k] : ifu_req_ready[k];
    end
    chk("xact_accept", 32'(ok), 32'd1);
    drive_pt();
    lsu_req_valid[k] = 1'b0;
    ifu_req_valid[k] = 1'b0;
    wait_drain();
    drive_pt();
    lsu_resp_ready[k] = 1'b0;
    ifu_resp_ready[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ifu_req_valid[k] = 1'b0; ifu_addr[k] = '0; ifu_resp_ready[k] = 1'b0;
      lsu_req_valid[k] = 1'b0; lsu_addr[k] = '0; lsu_wen[k] = 1'b0;
      lsu_wmask[k] = '0; lsu_wdata[k] = '0; lsu_resp_ready[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_re", 32'(mem_re[k]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[k]), 32'd0);
      chk("rst_mem_addr", mem_addr[k], 32'd0);
      chk("rst_ifu_rv", 32'(ifu_resp_valid[k]), 32'd0);
      chk("rst_lsu_rv", 32'(lsu_resp_valid[k]), 32'd0);
      chk("rst_lsu_rdata", lsu_rdata[k], 32'd0);
    end
    drive_pt();
    rst_n = 1'b1;

    // IFU read alone, LATENCY=1
    we0 = we_cnt[0];
    drive_pt();
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h8000_0000;
    @(negedge clk);
    chk("t1_ifu_rdy", 32'(ifu_req_ready[0]), 32'd1);
    chk("t1_lsu_rdy", 32'(lsu_req_ready[0]), 32'd0);
    drive_pt();
    ifu_req_valid[0] = 1'b0; ifu_addr[0] = 32'h0;
    @(negedge clk);
    chk("t1_re_c1", 32'(mem_re[0]), 32'd1);
    chk("t1_addr_c1", mem_addr[0], 32'h8000_0000);
    chk("t1_rv_c1", 32'(ifu_resp_valid[0]), 32'd0);
    drive_pt();
    ifu_resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t1_rv_c2", 32'(ifu_resp_valid[0]), 32'd1);
    chk("t1_re_c2", 32'(mem_re[0]), 32'd0);
    chk("t1_rdata", ifu_rdata[0], pat(0));
    drive_pt();
    ifu_resp_ready[0] = 1'b0;
    @(negedge clk);
    chk("t1_rv_c3", 32'(ifu_resp_valid[0]), 32'd0);
    chk("t1_no_we", 32'(we_cnt[0] - we0), 32'd0);

    // LSU write with response back-pressure, then read it back
    we0 = we_cnt[0];
    drive_pt();
    lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'h8000_0100; lsu_wen[0] = 1'b1;
    lsu_wmask[0] = 8'h0F; lsu_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_rdy", 32'(lsu_req_ready[0]), 32'd1);
    drive_pt();
    lsu_req_valid[0] = 1'b0; lsu_wdata[0] = 32'h0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) drive_pt();
      lsu_resp_ready[0] = (c == 6);
      @(negedge clk);
      chk("t2_we", 32'(mem_we[0]), 32'(c == 1));
      chk("t2_rv", 32'(lsu_resp_valid[0]), 32'(c >= 2 && c <= 6));
      if (c == 1) begin
        chk("t2_addr", mem_addr[0], 32'h8000_0100);
        chk("t2_mask", 32'(mem_mask[0]), 32'h0F);
        chk("t2_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      end
      if (lsu_resp_valid[0]) chk("t2_rdata0", lsu_rdata[0], 32'h0);
    end
    chk("t2_we_once", 32'(we_cnt[0] - we0), 32'd1);
    xact(0, 1'b1, 32'h8000_0100, 1'b0, 8'h00, 32'h0);

    // Both requesters valid continuously
    gnt_log.delete();
    drive_pt();
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h8000_0010; ifu_resp_ready[0] = 1'b1;
    lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'h8000_0020; lsu_wen[0] = 1'b0; lsu_resp_ready[0] = 1'b1;
    for (int i = 0; i < 200 && gnt_log.size() < 10; i++) @(negedge clk);
    chk("t3_ngrants", 32'(gnt_log.size() >= 10), 32'd1);
    drive_pt();
    ifu_req_valid[0] = 1'b0; lsu_req_valid[0] = 1'b0;
    wait_drain();
    drive_pt();
    ifu_resp_ready[0] = 1'b0; lsu_resp_ready[0] = 1'b0;
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      chk($sformatf("t3_grant%0d", i), 32'(gnt_log[i]), 32'((i % 5) != 4));

    // LATENCY=3 read; IFU waits until the return to IDLE
    re0 = re_cnt[1];
    drive_pt();
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 32'h8000_0040; lsu_wen[1] = 1'b0;
    @(negedge clk);
    chk("t4_rdy", 32'(lsu_req_ready[1]), 32'd1);
    drive_pt();
    lsu_req_valid[1] = 1'b0; ifu_req_valid[1] = 1'b1; ifu_addr[1] = 32'h8000_0080;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) drive_pt();
      lsu_resp_ready[1] = (c == 4);
      @(negedge clk);
      chk("t4_re", 32'(mem_re[1]), 32'(c == 3));
      chk("t4_ifu_blocked", 32'(ifu_req_ready[1]), 32'd0);
      chk("t4_rv", 32'(lsu_resp_valid[1]), 32'(c == 4));
    end
    drive_pt();
    lsu_resp_ready[1] = 1'b0; ifu_resp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_ifu_rdy_idle", 32'(ifu_req_ready[1]), 32'd1);
    drive_pt();
    ifu_req_valid[1] = 1'b0;
    wait_drain();
    drive_pt();
    ifu_resp_ready[1] = 1'b0;
    chk("t4_re_count", 32'(re_cnt[1] - re0), 32'd2);

    // Request inputs changed after acceptance are ignored
    drive_pt();
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 32'h8000_0200; lsu_wen[1] = 1'b1;
    lsu_wmask[1] = 8'h03; lsu_wdata[1] = 32'h5555_CAFE;
    @(negedge clk);
    chk("t5_rdy", 32'(lsu_req_ready[1]), 32'd1);
    drive_pt();
    lsu_req_valid[1] = 1'b0; lsu_addr[1] = 32'h8000_0300; lsu_wmask[1] = 8'hFF; lsu_wdata[1] = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) drive_pt();
      @(negedge clk);
      chk("t5_we", 32'(mem_we[1]), 32'(c == 3));
    end
    chk("t5_addr", mem_addr[1], 32'h8000_0200);
    chk("t5_mask", 32'(mem_mask[1]), 32'h03);
    chk("t5_wdata", mem_wdata[1], 32'h5555_CAFE);
    drive_pt();
    lsu_resp_ready[1] = 1'b1;
    wait_drain();
    drive_pt();
    lsu_resp_ready[1] = 1'b0;
    chk("t5_other_word", ram[8'hC0], pat(32'hC0));
    xact(1, 1'b1, 32'h8000_0200, 1'b0, 8'h00, 32'h0);

    // Reset during WAIT with a pending write
    drive_pt();
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 32'h8000_0180; lsu_wen[1] = 1'b1;
    lsu_wmask[1] = 8'h0F; lsu_wdata[1] = 32'h1122_3344;
    @(negedge clk);
    chk("t6_rdy", 32'(lsu_req_ready[1]), 32'd1);
    we0 = we_cnt[1];
    drive_pt();
    rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(mem_we[1]), 32'd0);
    chk("t6_re", 32'(mem_re[1]), 32'd0);
    chk("t6_lsu_rdy", 32'(lsu_req_ready[1]), 32'd0);
    chk("t6_rv", 32'(lsu_resp_valid[1]), 32'd0);
    chk("t6_addr", mem_addr[1], 32'h0);
    chk("t6_wdata", mem_wdata[1], 32'h0);
    lsu_req_valid[1] = 1'b0; lsu_wen[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_no_we", 32'(we_cnt[1] - we0), 32'd0);
    chk("t6_ram", ram[8'h60], model_rd(32'h8000_0180));
    drive_pt();
    rst_n = 1'b1;
    exp_q.delete();
    xact(1, 1'b1, 32'h8000_0180, 1'b0, 8'h00, 32'h0);
    xact(1, 1'b0, 32'h8000_0184, 1'b0, 8'h00, 32'h0);
    xact(0, 1'b0, 32'h8000_0100, 1'b0, 8'h00, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
